// File: rtl/master_tx_engine.sv
// Multi-lane serial master transmit engine: latches a request, arbitrates for the bus,
// shifts slave select then address/data LSB-first over LANES bits per beat, with timeouts and bounded retry.
module master_tx_engine #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int LANES     = 1,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SLAVE_LEN-1:0] slave_select,
    input  logic [1:0]           instruction,
    input  logic [ADDR_LEN-1:0]  address,
    input  logic [DATA_LEN-1:0]  data,
    input  logic                 rx_done,
    output logic                 master_ready,
    output logic                 tx_done,
    output logic                 tx_error,
    input  logic                 arbitor_busy,
    input  logic                 bus_busy,
    input  logic                 approval_grant,
    input  logic                 slave_ready,
    output logic                 approval_request,
    output logic                 master_valid,
    output logic                 write_en,
    output logic                 read_en,
    output logic [LANES-1:0]     tx_slave_select,
    output logic [LANES-1:0]     tx_address,
    output logic [LANES-1:0]     tx_data
);

    localparam int SB      = (SLAVE_LEN + LANES - 1) / LANES;
    localparam int AB      = (ADDR_LEN + LANES - 1) / LANES;
    localparam int DB      = (DATA_LEN + LANES - 1) / LANES;
    localparam int XBW     = (AB > DB) ? AB : DB;
    localparam int MAXB    = (XBW > SB) ? XBW : SB;
    localparam int BW      = $clog2(MAXB + 1);
    localparam int TW      = $clog2(TIMEOUT);
    localparam int RW      = $clog2(MAX_RETRY + 2);
    localparam int SEL_PAD = SB * LANES;
    localparam int X_PAD   = XBW * LANES;

    localparam logic [BW-1:0] SB_LAST = BW'(SB - 1);
    localparam logic [BW-1:0] AB_LAST = BW'(AB - 1);
    localparam logic [BW-1:0] XB_LAST = BW'(XBW - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_REQ        = 3'd1;
    localparam logic [2:0] ST_SEL        = 3'd2;
    localparam logic [2:0] ST_GRANT_WAIT = 3'd3;
    localparam logic [2:0] ST_HS_WAIT    = 3'd4;
    localparam logic [2:0] ST_XFER       = 3'd5;
    localparam logic [2:0] ST_READ_WAIT  = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [RW-1:0]        retryCnt_q, retryCnt_d;
    logic [SLAVE_LEN-1:0] selLatch_q, selLatch_d;
    logic [ADDR_LEN-1:0]  addrLatch_q, addrLatch_d;
    logic [DATA_LEN-1:0]  dataLatch_q, dataLatch_d;
    logic                 isRead_q, isRead_d;

    logic                 masterReady_q, masterReady_d;
    logic                 txDone_q, txDone_d;
    logic                 txError_q, txError_d;
    logic                 approvalReq_q, approvalReq_d;
    logic                 masterValid_q, masterValid_d;
    logic                 writeEn_q, writeEn_d;
    logic                 readEn_q, readEn_d;
    logic [LANES-1:0]     txSel_q, txSel_d;
    logic [LANES-1:0]     txAddr_q, txAddr_d;
    logic [LANES-1:0]     txData_q, txData_d;

    logic                 expired;
    logic                 retryReq;
    logic                 abort;
    logic [BW-1:0]        xferLast;
    logic [SEL_PAD-1:0]   selPad;
    logic [X_PAD-1:0]     addrPad;
    logic [X_PAD-1:0]     dataPad;

    assign selPad   = SEL_PAD'(selLatch_q);
    assign addrPad  = X_PAD'(addrLatch_q);
    assign dataPad  = X_PAD'(dataLatch_q);
    assign expired  = (timer_q == T_LAST);
    assign xferLast = isRead_q ? AB_LAST : XB_LAST;

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        beat_d      = beat_q;
        retryCnt_d  = retryCnt_q;
        selLatch_d  = selLatch_q;
        addrLatch_d = addrLatch_q;
        dataLatch_d = dataLatch_q;
        isRead_d    = isRead_q;
        retryReq    = 1'b0;
        abort       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instruction[1]) begin
                    selLatch_d  = slave_select;
                    addrLatch_d = address;
                    dataLatch_d = data;
                    isRead_d    = instruction[0];
                    retryCnt_d  = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!arbitor_busy && !bus_busy) begin
                    beat_d  = '0;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (beat_q == SB_LAST) state_d = ST_GRANT_WAIT;
                else                   beat_d  = beat_q + 1'b1;
            end
            // Grant wins over a simultaneous bus_busy; losing arbitration is not a retry.
            ST_GRANT_WAIT: begin
                if (approval_grant)  state_d  = ST_HS_WAIT;
                else if (bus_busy)   state_d  = ST_REQ;
                else if (expired)    retryReq = 1'b1;
            end
            ST_HS_WAIT: begin
                if (slave_ready) begin
                    beat_d  = '0;
                    state_d = ST_XFER;
                end else if (expired) begin
                    retryReq = 1'b1;
                end
            end
            ST_XFER: begin
                if (beat_q == xferLast) state_d = isRead_q ? ST_READ_WAIT : ST_DONE;
                else                    beat_d  = beat_q + 1'b1;
            end
            ST_READ_WAIT: begin
                if (rx_done) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (retryReq) begin
            if (retryCnt_q < MAX_R) begin
                retryCnt_d = retryCnt_q + 1'b1;
                state_d    = ST_REQ;
            end else begin
                abort   = 1'b1;
                state_d = ST_IDLE;
            end
        end

        if ((state_d == state_q) &&
            (state_q == ST_GRANT_WAIT || state_q == ST_HS_WAIT || state_q == ST_READ_WAIT))
            timer_d = timer_q + 1'b1;
    end

    // Output registers are loaded with the values belonging to the next state.
    always_comb begin
        masterReady_d = (state_d == ST_IDLE);
        approvalReq_d = (state_d == ST_REQ) || (state_d == ST_SEL);
        masterValid_d = (state_d == ST_HS_WAIT) || (state_d == ST_XFER);
        writeEn_d     = masterValid_d && !isRead_d;
        readEn_d      = masterValid_d && isRead_d;
        txDone_d      = (state_d == ST_XFER) && (beat_d == xferLast);
        txError_d     = abort;
        txSel_d       = txSel_q;
        txAddr_d      = txAddr_q;
        txData_d      = txData_q;
        if (state_d == ST_SEL)
            txSel_d = LANES'(selPad >> (32'(beat_d) * LANES));
        if (state_d == ST_XFER) begin
            txAddr_d = LANES'(addrPad >> (32'(beat_d) * LANES));
            txData_d = isRead_q ? '0 : LANES'(dataPad >> (32'(beat_d) * LANES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            beat_q        <= '0;
            retryCnt_q    <= '0;
            selLatch_q    <= '0;
            addrLatch_q   <= '0;
            dataLatch_q   <= '0;
            isRead_q      <= 1'b0;
            masterReady_q <= 1'b1;
            txDone_q      <= 1'b0;
            txError_q     <= 1'b0;
            approvalReq_q <= 1'b0;
            masterValid_q <= 1'b0;
            writeEn_q     <= 1'b0;
            readEn_q      <= 1'b0;
            txSel_q       <= '0;
            txAddr_q      <= '0;
            txData_q      <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            beat_q        <= beat_d;
            retryCnt_q    <= retryCnt_d;
            selLatch_q    <= selLatch_d;
            addrLatch_q   <= addrLatch_d;
            dataLatch_q   <= dataLatch_d;
            isRead_q      <= isRead_d;
            masterReady_q <= masterReady_d;
            txDone_q      <= txDone_d;
            txError_q     <= txError_d;
            approvalReq_q <= approvalReq_d;
            masterValid_q <= masterValid_d;
            writeEn_q     <= writeEn_d;
            readEn_q      <= readEn_d;
            txSel_q       <= txSel_d;
            txAddr_q      <= txAddr_d;
            txData_q      <= txData_d;
        end
    end

    assign master_ready     = masterReady_q;
    assign tx_done          = txDone_q;
    assign tx_error         = txError_q;
    assign approval_request = approvalReq_q;
    assign master_valid     = masterValid_q;
    assign write_en         = writeEn_q;
    assign read_en          = readEn_q;
    assign tx_slave_select  = txSel_q;
    assign tx_address       = txAddr_q;
    assign tx_data          = txData_q;

endmodule

// File: tb/tb_master_tx_engine.sv
// Bench for master_tx_engine: three instances (LANES 1, 4, 3) share stimulus; each scenario
// task checks one instance, with expected beats queued at request time and popped per beat.
module tb_master_tx_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  slave_select;
    logic [1:0]  instruction;
    logic [11:0] address;
    logic [7:0]  data;
    logic        rx_done, arbitor_busy, bus_busy, approval_grant, slave_ready;

    logic       aReady, aDone, aErr, aReq, aValid, aWr, aRd;
    logic       aSel, aAddr, aData;
    logic       bReady, bDone, bErr, bReq, bValid, bWr, bRd;
    logic [3:0] bSel, bAddr, bData;
    logic       cReady, cDone, cErr, cReq, cValid, cWr, cRd;
    logic [2:0] cSel, cAddr, cData;

    int checks = 0;
    int errors = 0;

    logic [7:0] expSel[$];
    logic [7:0] expAddr[$];
    logic [7:0] expData[$];

    master_tx_engine #(.LANES(1)) dutA (
        .clk(clk), .reset(reset), .slave_select(slave_select), .instruction(instruction),
        .address(address), .data(data), .rx_done(rx_done), .master_ready(aReady),
        .tx_done(aDone), .tx_error(aErr), .arbitor_busy(arbitor_busy), .bus_busy(bus_busy),
        .approval_grant(approval_grant), .slave_ready(slave_ready), .approval_request(aReq),
        .master_valid(aValid), .write_en(aWr), .read_en(aRd),
        .tx_slave_select(aSel), .tx_address(aAddr), .tx_data(aData)
    );

    master_tx_engine #(.LANES(4)) dutB (
        .clk(clk), .reset(reset), .slave_select(slave_select), .instruction(instruction),
        .address(address), .data(data), .rx_done(rx_done), .master_ready(bReady),
        .tx_done(bDone), .tx_error(bErr), .arbitor_busy(arbitor_busy), .bus_busy(bus_busy),
        .approval_grant(approval_grant), .slave_ready(slave_ready), .approval_request(bReq),
        .master_valid(bValid), .write_en(bWr), .read_en(bRd),
        .tx_slave_select(bSel), .tx_address(bAddr), .tx_data(bData)
    );

    master_tx_engine #(.LANES(3)) dutC (
        .clk(clk), .reset(reset), .slave_select(slave_select), .instruction(instruction),
        .address(address), .data(data), .rx_done(rx_done), .master_ready(cReady),
        .tx_done(cDone), .tx_error(cErr), .arbitor_busy(arbitor_busy), .bus_busy(bus_busy),
        .approval_grant(approval_grant), .slave_ready(slave_ready), .approval_request(cReq),
        .master_valid(cValid), .write_en(cWr), .read_en(cRd),
        .tx_slave_select(cSel), .tx_address(cAddr), .tx_data(cData)
    );

    // Reference beat model: lane i of beat k is bit k*lanes+i of the field, zero past its width.
    function automatic logic [7:0] beatOf(input logic [31:0] f, input int width, input int lanes, input int k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < lanes; i++)
            if (k * lanes + i < width) r[i] = f[k * lanes + i];
        return r;
    endfunction

    task automatic pushBeats(input logic [31:0] selF, input logic [31:0] addrF, input logic [31:0] dataF,
                             input int lanes, input bit isRead);
        int sb, ab, db, xb;
        sb = (2 + lanes - 1) / lanes;
        ab = (12 + lanes - 1) / lanes;
        db = (8 + lanes - 1) / lanes;
        xb = isRead ? ab : ((ab > db) ? ab : db);
        for (int k = 0; k < sb; k++) expSel.push_back(beatOf(selF, 2, lanes, k));
        for (int k = 0; k < xb; k++) begin
            expAddr.push_back(beatOf(addrF, 12, lanes, k));
            expData.push_back(isRead ? 8'h00 : beatOf(dataF, 8, lanes, k));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [1:0] instr,
                                 input logic [11:0] addr, input logic [7:0] dat);
        slave_select = sel;
        instruction  = instr;
        address      = addr;
        data         = dat;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 12'h000, 8'h00);
        rx_done = 1'b0; arbitor_busy = 1'b0; bus_busy = 1'b0;
        approval_grant = 1'b0; slave_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        expSel.delete();
        expAddr.delete();
        expData.delete();
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({aReady, aDone, aErr, aReq, aValid, aWr, aRd, aSel, aAddr, aData} !== 10'b1000000000) begin
            errors++;
            $display("[TB] FAIL resetA: got %b expected %b",
                     {aReady, aDone, aErr, aReq, aValid, aWr, aRd, aSel, aAddr, aData}, 10'b1000000000);
        end
        checks++;
        if ({bReady, bDone, bErr, bReq, bValid, bWr, bRd, bSel, bAddr, bData} !== 19'h40000) begin
            errors++;
            $display("[TB] FAIL resetB: got %h expected %h",
                     {bReady, bDone, bErr, bReq, bValid, bWr, bRd, bSel, bAddr, bData}, 19'h40000);
        end
        checks++;
        if ({cReady, cDone, cErr, cReq, cValid, cWr, cRd, cSel, cAddr, cData} !== 16'h8000) begin
            errors++;
            $display("[TB] FAIL resetC: got %h expected %h",
                     {cReady, cDone, cErr, cReq, cValid, cWr, cRd, cSel, cAddr, cData}, 16'h8000);
        end
    endtask

    // Inputs are scrambled right after accept, so every beat must come from the latched request.
    task automatic test_write_lanes1();
        logic [7:0] e;
        doReset();
        slave_ready = 1'b1;
        applyStimulus(2'b10, 2'b10, 12'hA5C, 8'h3C);
        pushBeats(32'h2, 32'hA5C, 32'h3C, 1, 1'b0);
        tick();
        applyStimulus(2'b01, 2'b11, 12'h000, 8'hFF);
        checks++;
        if ({aReq, aReady} !== 2'b10) begin
            errors++; $display("[TB] FAIL w1_req: got %b expected 10", {aReq, aReady});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            e = expSel.pop_front();
            checks++;
            if ({7'b0, aSel} !== e) begin
                errors++; $display("[TB] FAIL w1_sel beat %0d: got %0h expected %0h", k, aSel, e);
            end
        end
        tick();
        checks++;
        if ({aReq, aSel} !== 2'b01) begin
            errors++; $display("[TB] FAIL w1_gw_hold: got %b expected 01", {aReq, aSel});
        end
        tick();
        approval_grant = 1'b1;
        tick();
        approval_grant = 1'b0;
        checks++;
        if ({aValid, aWr, aRd} !== 3'b110) begin
            errors++; $display("[TB] FAIL w1_hs: got %b expected 110", {aValid, aWr, aRd});
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 11) instruction = 2'b00;
            e = expAddr.pop_front();
            checks++;
            if ({7'b0, aAddr} !== e) begin
                errors++; $display("[TB] FAIL w1_addr beat %0d: got %0h expected %0h", k, aAddr, e);
            end
            e = expData.pop_front();
            checks++;
            if ({7'b0, aData} !== e) begin
                errors++; $display("[TB] FAIL w1_data beat %0d: got %0h expected %0h", k, aData, e);
            end
            checks++;
            if (aDone !== (k == 11)) begin
                errors++; $display("[TB] FAIL w1_done beat %0d: got %b expected %b", k, aDone, (k == 11));
            end
        end
        tick();
        checks++;
        if ({aReady, aValid, aWr, aDone} !== 4'b0000) begin
            errors++; $display("[TB] FAIL w1_doneState: got %b expected 0000", {aReady, aValid, aWr, aDone});
        end
        tick();
        checks++;
        if (aReady !== 1'b1) begin
            errors++; $display("[TB] FAIL w1_ready: got %b expected 1", aReady);
        end
    endtask

    task automatic test_read_lanes4();
        logic [7:0] e;
        int n;
        bit seen;
        doReset();
        slave_ready = 1'b1;
        approval_grant = 1'b1;
        applyStimulus(2'b01, 2'b11, 12'h123, 8'hAA);
        pushBeats(32'h1, 32'h123, 32'hAA, 4, 1'b1);
        tick();
        instruction = 2'b00;
        tick();
        e = expSel.pop_front();
        checks++;
        if ({4'b0, bSel} !== e) begin
            errors++; $display("[TB] FAIL r4_sel: got %0h expected %0h", bSel, e);
        end
        tick();
        tick();
        checks++;
        if ({bValid, bWr, bRd} !== 3'b101) begin
            errors++; $display("[TB] FAIL r4_hs: got %b expected 101", {bValid, bWr, bRd});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            e = expAddr.pop_front();
            checks++;
            if ({4'b0, bAddr} !== e) begin
                errors++; $display("[TB] FAIL r4_addr beat %0d: got %0h expected %0h", k, bAddr, e);
            end
            e = expData.pop_front();
            checks++;
            if ({4'b0, bData} !== e) begin
                errors++; $display("[TB] FAIL r4_data beat %0d: got %0h expected %0h", k, bData, e);
            end
            checks++;
            if (bDone !== (k == 2)) begin
                errors++; $display("[TB] FAIL r4_done beat %0d: got %b expected %b", k, bDone, (k == 2));
            end
        end
        tick();
        checks++;
        if ({bValid, bRd, bReady} !== 3'b000) begin
            errors++; $display("[TB] FAIL r4_readWait: got %b expected 000", {bValid, bRd, bReady});
        end
        tick();
        tick();
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        checks++;
        if ({bReady, bErr} !== 2'b10) begin
            errors++; $display("[TB] FAIL r4_rxDone: got %b expected 10", {bReady, bErr});
        end

        applyStimulus(2'b01, 2'b11, 12'h123, 8'hAA);
        tick();
        instruction = 2'b00;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = bDone;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL r4_doneWait: got no tx_done expected one within 20 cycles");
        end
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (bReady) seen = 1'b1;
            else begin
                n++;
                checks++;
                if (bErr !== 1'b0) begin
                    errors++; $display("[TB] FAIL r4_earlyErr cycle %0d: got 1 expected 0", n);
                end
            end
        end
        checks++;
        if (n !== 16) begin
            errors++; $display("[TB] FAIL r4_timeoutLen: got %0d expected 16", n);
        end
        checks++;
        if (bErr !== 1'b1) begin
            errors++; $display("[TB] FAIL r4_timeoutErr: got %b expected 1", bErr);
        end
        tick();
        checks++;
        if (bErr !== 1'b0) begin
            errors++; $display("[TB] FAIL r4_errPulse: got %b expected 0", bErr);
        end
    endtask

    task automatic test_lanes3_padding();
        logic [7:0] e;
        doReset();
        slave_ready = 1'b1;
        approval_grant = 1'b1;
        applyStimulus(2'b11, 2'b10, 12'hFFF, 8'hFF);
        pushBeats(32'h3, 32'hFFF, 32'hFF, 3, 1'b0);
        tick();
        instruction = 2'b00;
        tick();
        e = expSel.pop_front();
        checks++;
        if ({5'b0, cSel} !== e) begin
            errors++; $display("[TB] FAIL l3_sel: got %0h expected %0h", cSel, e);
        end
        tick();
        tick();
        checks++;
        if ({cValid, cWr} !== 2'b11) begin
            errors++; $display("[TB] FAIL l3_hs: got %b expected 11", {cValid, cWr});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            e = expAddr.pop_front();
            checks++;
            if ({5'b0, cAddr} !== e) begin
                errors++; $display("[TB] FAIL l3_addr beat %0d: got %0h expected %0h", k, cAddr, e);
            end
            e = expData.pop_front();
            checks++;
            if ({5'b0, cData} !== e) begin
                errors++; $display("[TB] FAIL l3_data beat %0d: got %0h expected %0h", k, cData, e);
            end
        end
        tick();
        tick();
        checks++;
        if (cReady !== 1'b1) begin
            errors++; $display("[TB] FAIL l3_ready: got %b expected 1", cReady);
        end
    endtask

    // A bus_busy pulse cuts the first grant wait short without consuming a retry; four full waits follow.
    task automatic test_retry_lost_arb();
        int runs[8];
        int nRuns, runLen;
        bit finished, pulsed, errAtEnd;
        doReset();
        applyStimulus(2'b10, 2'b10, 12'h5A5, 8'h11);
        tick();
        instruction = 2'b00;
        nRuns = 0; runLen = 0; finished = 1'b0; pulsed = 1'b0; errAtEnd = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            tick();
            bus_busy = 1'b0;
            if (aReady) begin
                if (runLen > 0 && nRuns < 8) begin runs[nRuns] = runLen; nRuns++; end
                errAtEnd = aErr;
                finished = 1'b1;
            end else if (!aReq) begin
                runLen++;
                if (nRuns == 0 && runLen == 6 && !pulsed) begin
                    bus_busy = 1'b1;
                    pulsed = 1'b1;
                end
            end else if (runLen > 0) begin
                if (nRuns < 8) begin runs[nRuns] = runLen; nRuns++; end
                runLen = 0;
            end
        end
        checks++;
        if (!finished) begin
            errors++; $display("[TB] FAIL retry_finish: got no return to idle expected one within 300 cycles");
        end
        checks++;
        if (nRuns !== 5) begin
            errors++; $display("[TB] FAIL retry_episodes: got %0d expected 5", nRuns);
        end
        checks++;
        if (runs[0] !== 6) begin
            errors++; $display("[TB] FAIL retry_lostArbLen: got %0d expected 6", runs[0]);
        end
        for (int r = 1; r < 5; r++) begin
            checks++;
            if (runs[r] !== 16) begin
                errors++; $display("[TB] FAIL retry_waitLen %0d: got %0d expected 16", r, runs[r]);
            end
        end
        checks++;
        if (errAtEnd !== 1'b1) begin
            errors++; $display("[TB] FAIL retry_err: got %b expected 1", errAtEnd);
        end
        tick();
        checks++;
        if ({aErr, aReady} !== 2'b01) begin
            errors++; $display("[TB] FAIL retry_errPulse: got %b expected 01", {aErr, aReady});
        end
    endtask

    task automatic test_simultaneous_reset();
        doReset();
        slave_ready = 1'b1;
        applyStimulus(2'b10, 2'b10, 12'hA5C, 8'h3C);
        tick();
        instruction = 2'b00;
        tick();
        tick();
        tick();
        approval_grant = 1'b1;
        bus_busy = 1'b1;
        tick();
        approval_grant = 1'b0;
        bus_busy = 1'b0;
        checks++;
        if ({aValid, aWr, aReq} !== 3'b110) begin
            errors++; $display("[TB] FAIL sim_grantWins: got %b expected 110", {aValid, aWr, aReq});
        end
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({aReady, aDone, aErr, aReq, aValid, aWr, aRd, aSel, aAddr, aData} !== 10'b1000000000) begin
            errors++;
            $display("[TB] FAIL sim_midReset: got %b expected %b",
                     {aReady, aDone, aErr, aReq, aValid, aWr, aRd, aSel, aAddr, aData}, 10'b1000000000);
        end
        tick();
        checks++;
        if ({aReady, aValid} !== 2'b10) begin
            errors++; $display("[TB] FAIL sim_staysIdle: got %b expected 10", {aReady, aValid});
        end
    endtask

    initial begin
        test_reset();
        test_write_lanes1();
        test_read_lanes4();
        test_lanes3_padding();
        test_retry_lost_arb();
        test_simultaneous_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
